cfg_chain_loader: RTL and testbench

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

---
 rtl/cfg_chain_loader.sv | 176 +++++++++++++++++
 tb/tb_cfg_chain_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: serial-to-parallel configuration loader for a chain of
// latch-based target blocks. Bits arrive MSB-first on bit_in/bit_valid, are
// assembled into config_out, and each completed word is committed to block k
// with a single-cycle one-hot cen pulse. Blocks 0..NUM_BLOCKS-1 are loaded in
// order, and a one-cycle done pulse follows the last block.
//
// Optional feature: define CFG_CHAIN_LOADER_PARITY_EN to require one even
// parity bit after every word. A mismatch parks the loader in ERR with a
// sticky err flag until start or rst.
//
// Handshake: a bit transfers on a rising cclk edge where bit_valid=1 and
// in_ready=1. in_ready is high only in SHIFT. Bits offered while in_ready=0
// are not consumed, so the source must hold them until in_ready returns.
//
// state_dbg exposes the FSM state: 0=IDLE 1=SHIFT 2=LOAD 3=DONE 4=ERR.
module cfg_chain_loader #(
    parameter int ADDR_BITS  = 4,
    parameter int MEM_SIZE   = 2**ADDR_BITS,
    parameter int NUM_BLOCKS = 8
) (
    input  logic                  cclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  in_ready,
    output logic [MEM_SIZE-1:0]   config_out,
    output logic [NUM_BLOCKS-1:0] cen,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            state_dbg
);

    localparam int CW = $clog2(MEM_SIZE + 2);
    localparam int KW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    localparam logic [CW-1:0]         LAST_DATA = CW'(MEM_SIZE - 1);
    localparam logic [KW-1:0]         LAST_BLK  = KW'(NUM_BLOCKS - 1);
    localparam logic [NUM_BLOCKS-1:0] CEN_ONE   = NUM_BLOCKS'(1);
`ifdef CFG_CHAIN_LOADER_PARITY_EN
    localparam logic [CW-1:0]         PAR_SLOT  = CW'(MEM_SIZE);
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_LOAD  = 3'd2,
        S_DONE  = 3'd3
`ifdef CFG_CHAIN_LOADER_PARITY_EN
        ,
        S_ERR   = 3'd4
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;  // bits accepted for the current word
    logic [KW-1:0] k;    // index of the block being loaded
    logic          accept;

`ifdef CFG_CHAIN_LOADER_PARITY_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign accept    = bit_valid & in_ready;
    assign state_dbg = state;

    // Loader FSM: owns the shift register, counters and all registered outputs.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            k          <= '0;
            config_out <= '0;
            cen        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef CFG_CHAIN_LOADER_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // cen and done are single-cycle pulses
            cen  <= '0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SHIFT;
                        cnt      <= '0;
                        k        <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
`ifdef CFG_CHAIN_LOADER_PARITY_EN
                        err_q    <= 1'b0;
`endif
                    end
                end

                S_SHIFT: begin
                    if (accept) begin
`ifdef CFG_CHAIN_LOADER_PARITY_EN
                        if (cnt == PAR_SLOT) begin
                            // parity bit: checked against the held word, never shifted in
                            in_ready <= 1'b0;
                            if ((^config_out) ^ bit_in) begin
                                state <= S_ERR;
                                err_q <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_LOAD;
                                cen   <= CEN_ONE << k;
                            end
                        end else begin
                            config_out <= {config_out[MEM_SIZE-2:0], bit_in};
                            cnt        <= cnt + CW'(1);
                        end
`else
                        config_out <= {config_out[MEM_SIZE-2:0], bit_in};
                        cnt        <= cnt + CW'(1);
                        if (cnt == LAST_DATA) begin
                            state    <= S_LOAD;
                            in_ready <= 1'b0;
                            cen      <= CEN_ONE << k;
                        end
`endif
                    end
                end

                S_LOAD: begin
                    if (k == LAST_BLK) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_SHIFT;
                        k        <= k + KW'(1);
                        cnt      <= '0;
                        in_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

`ifdef CFG_CHAIN_LOADER_PARITY_EN
                S_ERR: begin
                    if (start) begin
                        state    <= S_SHIFT;
                        cnt      <= '0;
                        k        <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        err_q    <= 1'b0;
                    end
                end
`endif

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifndef CFG_CHAIN_LOADER_PARITY_EN
    // LAST_DATA is the only word-length compare when no parity slot exists
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Testbench for cfg_chain_loader (NUM_BLOCKS=2, MEM_SIZE=16).
// Table-driven full loads plus hand-written sequences for ignored inputs,
// reset during LOAD and (when CFG_CHAIN_LOADER_PARITY_EN is defined) parity.
module tb_cfg_chain_loader;

  localparam int MS = 16;
  localparam int NB = 2;

  // clock / reset
  logic cclk = 1'b0;
  logic rst;
  logic start;
  logic bit_in;
  logic bit_valid;
  logic in_ready;
  logic [MS-1:0] config_out;
  logic [NB-1:0] cen;
  logic busy;
  logic done;
  logic err;
  logic [2:0] state_dbg;

  always #5 cclk = ~cclk;

  cfg_chain_loader #(
    .ADDR_BITS (4),
    .MEM_SIZE  (MS),
    .NUM_BLOCKS(NB)
  ) dut (
    .cclk      (cclk),
    .rst       (rst),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .in_ready  (in_ready),
    .config_out(config_out),
    .cen       (cen),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  logic [MS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic send_bit(input logic b, input bit gap);
    int waits;
    if (gap) begin
      bit_valid = 1'b0;
      @(negedge cclk);
      check("gap_no_cen", cen, 0);
    end
    bit_in = b;
    bit_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge cclk);
      waits++;
    end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    @(negedge cclk);
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [MS-1:0] w, input bit gap, input int blk, input int glitch);
    logic [NB-1:0] ecen;
    logic [MS-1:0] ew;
    for (int i = MS - 1; i >= 0; i--) begin
      if (i == glitch) start = 1'b1;
      send_bit(w[i], gap);
      start = 1'b0;
    end
`ifdef CFG_CHAIN_LOADER_PARITY_EN
    send_bit(^w, gap);
`endif
    ecen = '0;
    ecen[blk] = 1'b1;
    ew = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("load_state", state_dbg, 2);
    check("load_cen", cen, ecen);
    check("load_word", config_out, ew);
    check("load_in_ready", in_ready, 0);
  endtask

  task automatic run_load(input logic [MS-1:0] w0, input logic [MS-1:0] w1,
                          input bit gap, input int glitch);
    @(negedge cclk);
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_in_ready", in_ready, 1);
    check("start_state", state_dbg, 1);
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    send_word(w0, gap, 0, glitch);
    send_word(w1, gap, 1, -1);
    @(negedge cclk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_cen", cen, 0);
    @(negedge cclk);
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("after_in_ready", in_ready, 0);
    check("after_hold", config_out, w1);
  endtask

  typedef struct {
    logic [MS-1:0] w0;
    logic [MS-1:0] w1;
    bit            gap;
    logic [MS-1:0] exp0;
    logic [MS-1:0] exp1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{w0: 16'hA5C3, w1: 16'h0F0F, gap: 1'b0, exp0: 16'hA5C3, exp1: 16'h0F0F};
    vecs[1] = '{w0: 16'hA5C3, w1: 16'h0F0F, gap: 1'b1, exp0: 16'hA5C3, exp1: 16'h0F0F};
    vecs[2] = '{w0: 16'h0000, w1: 16'hFFFF, gap: 1'b0, exp0: 16'h0000, exp1: 16'hFFFF};
    vecs[3] = '{w0: 16'h8001, w1: 16'h7FFE, gap: 1'b1, exp0: 16'h8001, exp1: 16'h7FFE};

    // reset state
    rst = 1'b1;
    start = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    #1;
    check("rst_state", state_dbg, 0);
    check("rst_cen", cen, 0);
    check("rst_word", config_out, 0);
    check("rst_flags", {in_ready, busy, done, err}, 0);
    repeat (3) @(negedge cclk);
    rst = 1'b0;
    @(negedge cclk);
    check("idle_state", state_dbg, 0);

    // table-driven full loads
    for (int v = 0; v < 4; v++) begin
      run_load(vecs[v].w0, vecs[v].w1, vecs[v].gap, -1);
      check("vec_word1", config_out, vecs[v].exp1);
    end

    // bits offered in IDLE are dropped
    for (int i = 0; i < 5; i++) begin
      bit_in = i[0];
      bit_valid = 1'b1;
      @(negedge cclk);
      check("idle_no_ready", in_ready, 0);
    end
    bit_valid = 1'b0;
    check("idle_word_kept", config_out, 16'h7FFE);
    check("idle_still", state_dbg, 0);

    // start pulsed mid-SHIFT (with bit 10 of word 0) must not restart
    run_load(16'hA5C3, 16'h0F0F, 1'b0, 10);

    // reset during LOAD of block 0
    @(negedge cclk);
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1'b0, 0, -1);
    rst = 1'b1;
    #1;
    check("midrst_cen", cen, 0);
    check("midrst_word", config_out, 0);
    check("midrst_state", state_dbg, 0);
    check("midrst_flags", {in_ready, busy, done}, 0);
    @(negedge cclk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge cclk);
      check("post_rst_quiet", {cen, done}, 0);
    end
    check("post_rst_idle", state_dbg, 0);

`ifdef CFG_CHAIN_LOADER_PARITY_EN
    // good parity on block 0, bad parity on block 1
    @(negedge cclk);
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
    exp_q.push_back(16'h0001);
    send_word(16'h0001, 1'b0, 0, -1);
    begin
      logic [MS-1:0] bad_w;
      bad_w = 16'h0003;
      for (int i = MS - 1; i >= 0; i--) send_bit(bad_w[i], 1'b0);
    end
    send_bit(1'b1, 1'b0);
    check("par_err_state", state_dbg, 4);
    check("par_err_flag", err, 1);
    check("par_err_cen", cen, 0);
    check("par_err_ready", in_ready, 0);
    check("par_err_busy", busy, 0);
    repeat (5) begin
      @(negedge cclk);
      check("par_err_sticky", {err, done, cen}, 4'b1000);
    end
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
    check("par_restart_err", err, 0);
    check("par_restart_state", state_dbg, 1);
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 1'b0, 0, -1);
    rst = 1'b1;
    @(negedge cclk);
    rst = 1'b0;
    exp_q.delete();
`else
    check("no_parity_err", err, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
